// File: rtl/exec_sequencer.sv
// exec_sequencer -- multicycle fetch/decode/execute control unit.
//
// Fetches 8-bit instructions from a synchronous ROM (data valid the cycle after
// imem_rd), decodes them into op/dest/src fields and issues a one-cycle exec_en
// strobe per non-HALT instruction. Four cycles per instruction:
// FETCH -> WAIT -> DECODE -> EXEC.
//
// Optional feature: define SEQ_SINGLE_STEP_EN to add the `step` input and a
// PAUSE state entered after every EXEC; step=1 in PAUSE resumes with a FETCH.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             run request (honoured only in IDLE/HALT)
//   step              (SEQ_SINGLE_STEP_EN only) advance out of PAUSE
//   imem_rd/addr      ROM read strobe and address (address = pc)
//   imem_data         ROM data, captured in WAIT only
//   op_code, dest_addr, src_addr1, src_addr2   decoded IR fields
//   exec_en           one-cycle execute/writeback strobe
//   busy, halted      status (busy in any state except IDLE/HALT)
//   pc                program counter, wraps modulo 2**PC_W
//   instr_count       number of exec_en pulses, saturating

module exec_sequencer #(
   parameter int PC_W  = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic             imem_rd,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [7:0]       imem_data,
   output logic [1:0]       op_code,
   output logic [1:0]       dest_addr,
   output logic [1:0]       src_addr1,
   output logic [1:0]       src_addr2,
   output logic             exec_en,
   output logic             busy,
   output logic             halted,
   output logic [PC_W-1:0]  pc,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_EXEC,
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE,
`endif
      S_HALT
   } state_t;

   localparam logic [1:0] OP_HALT = 2'b11;

   state_t     state, state_nxt;
   logic [7:0] ir;
   logic       ir_ld, pc_inc, pc_clr;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state and control decode
   always_comb begin
      state_nxt = state;
      imem_rd   = 1'b0;
      exec_en   = 1'b0;
      busy      = 1'b1;
      halted    = 1'b0;
      ir_ld     = 1'b0;
      pc_inc    = 1'b0;
      pc_clr    = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_rd   = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            ir_ld     = 1'b1;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            // HALT opcode never reaches EXEC, so it neither strobes nor advances pc
            if (ir[7:6] == OP_HALT) state_nxt = S_HALT;
            else                    state_nxt = S_EXEC;
         end
         S_EXEC: begin
            exec_en = 1'b1;
            pc_inc  = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
            state_nxt = S_PAUSE;
`else
            state_nxt = S_FETCH;
`endif
         end
`ifdef SEQ_SINGLE_STEP_EN
         S_PAUSE: begin
            // start has no effect here; only step resumes
            if (step) state_nxt = S_FETCH;
         end
`endif
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
            if (start) begin
               pc_clr    = 1'b1;   // restart from address 0, count is kept
               state_nxt = S_FETCH;
            end
         end
         default: begin
            busy      = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // datapath: IR, pc, retired counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir          <= '0;
         pc          <= '0;
         instr_count <= '0;
      end else begin
         if (ir_ld) ir <= imem_data;
         if (pc_clr)      pc <= '0;
         else if (pc_inc) pc <= pc + 1'b1;   // natural wrap
         if (pc_inc && (instr_count != {CNT_W{1'b1}}))
            instr_count <= instr_count + 1'b1;
      end
   end

   // IR is loaded on the WAIT->DECODE edge, so the fields change exactly when
   // DECODE begins and hold through EXEC until the next DECODE.
   assign op_code   = ir[7:6];
   assign dest_addr = ir[5:4];
   assign src_addr1 = ir[3:2];
   assign src_addr2 = ir[1:0];
   assign imem_addr = pc;

endmodule
